// File: rtl/transpose_buffer.sv
// Ping-pong N x N transpose buffer: rows are written into one bank while the other
// bank is read out column-by-column (transpose) or row-by-row (pass-through).
module transpose_buffer #(
  parameter int N = 8,
  parameter int W = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  input  logic           in_tr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_vec,
  output logic           out_last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshake: a beat transfers on a rising clk edge where valid and ready are both
  // high; valid/data hold until that edge, and ready/valid come from registers only.

  logic [W-1:0]  bank_q [2][N][N];
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          accept;
  logic          emit;

  assign in_ready  = ~full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign out_last  = out_valid & (rd_cnt_q == LAST);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // Sample storage is data-only and deliberately left without reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < N; c++) begin
        bank_q[wr_sel_q][wr_cnt_q][c] <= in_row[c*W +: W];
      end
    end
  end

  always_comb begin
    out_vec = '0;
    if (out_valid) begin
      for (int k = 0; k < N; k++) begin
        out_vec[k*W +: W] = mode_q[rd_sel_q] ? bank_q[rd_sel_q][k][rd_cnt_q]
                                             : bank_q[rd_sel_q][rd_cnt_q][k];
      end
    end
  end

  // Write and read sides always touch different full[] bits, so both updates apply.
  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    full_d   = full_q;
    mode_d   = mode_q;
    if (accept) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == '0) begin
        mode_d[wr_sel_q] = in_tr;
      end
      if (wr_cnt_q == LAST) begin
        wr_cnt_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end
    if (emit) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST) begin
        rd_cnt_d         = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q   <= '0;
      mode_q   <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q   <= full_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: tb/tb_transpose_buffer.sv
// Bench for transpose_buffer: block-level reference model checked every cycle,
// plus directed scenarios with hand-computed values (N=8/W=18 and N=4/W=12).
module tb_transpose_buffer;

  typedef struct {
    logic [143:0] row;
    logic         tr;
  } stim_t;

  typedef struct {
    logic [143:0] r [8];
    logic         tr;
  } blk_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst8_n = 1'b0;
  logic rst4_n = 1'b0;

  // shared stimulus and per-instance outputs
  logic         in_valid  = 1'b0;
  logic [143:0] in_row    = '0;
  logic         in_tr     = 1'b0;
  logic         out_ready = 1'b0;
  logic         r8, v8, l8, r4, v4, l4;
  logic [143:0] vec8;
  logic [47:0]  vec4;

  transpose_buffer #(.N(8), .W(18)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid), .in_ready(r8), .in_row(in_row),
    .in_tr(in_tr), .out_valid(v8), .out_ready(out_ready), .out_vec(vec8), .out_last(l8)
  );

  transpose_buffer #(.N(4), .W(12)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid), .in_ready(r4), .in_row(in_row[47:0]),
    .in_tr(in_tr), .out_valid(v4), .out_ready(out_ready), .out_vec(vec4), .out_last(l4)
  );

  // currently observed instance
  logic         sel = 1'b0;
  int           n = 8;
  int           w = 18;
  logic [143:0] emask = (144'd1 << 18) - 144'd1;
  logic [143:0] rmask = '1;
  logic         c_ready, c_valid, c_last, c_rst;
  logic [143:0] c_vec;
  assign c_ready = sel ? r4 : r8;
  assign c_valid = sel ? v4 : v8;
  assign c_last  = sel ? l4 : l8;
  assign c_vec   = sel ? {96'b0, vec4} : vec8;
  assign c_rst   = sel ? rst4_n : rst8_n;

  // scoreboard / model state
  stim_t stim_q[$];
  blk_t  done_q[$];
  blk_t  cur;
  int    cur_n = 0;
  int    m_beat = 0;
  int    m_acc = 0;
  int    m_emit = 0;
  int    dut_beats = 0;
  int    n_cmp = 0;
  int    n_mis = 0;
  int    or_mode = 1;
  bit    iv_rand = 1'b0;

  task automatic checkv(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [143:0] el(input logic [143:0] v, input int k);
    return (v >> (k * w)) & emask;
  endfunction

  // Beat m_beat of the oldest complete block: column m_beat if transposing, else row m_beat.
  function automatic logic [143:0] exp_vec();
    logic [143:0] v;
    v = '0;
    if (done_q.size() == 0) return v;
    if (done_q[0].tr) begin
      for (int k = 0; k < n; k++) v |= el(done_q[0].r[k], m_beat) << (k * w);
    end else begin
      v = done_q[0].r[m_beat];
    end
    return v;
  endfunction

  task automatic model_clear();
    stim_q.delete();
    done_q.delete();
    cur_n  = 0;
    m_beat = 0;
  endtask

  // element (r,c) = base + r*n + c; later rows optionally carry the inverted mode bit
  task automatic push_block(input int base, input logic tr, input bit toggle);
    stim_t s;
    for (int r = 0; r < n; r++) begin
      s.row = '0;
      for (int c = 0; c < n; c++) s.row |= (144'(base + r * n + c) & emask) << (c * w);
      s.tr = (r == 0) ? tr : (toggle ? ~tr : tr);
      stim_q.push_back(s);
    end
  endtask

  task automatic wait_cnt(input string name, input bit on_emit, input int target, input int budget);
    int k;
    k = 0;
    while (((on_emit ? m_emit : m_acc) < target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    checkv({name, "_reached"}, 144'((on_emit ? m_emit : m_acc) >= target), 144'd1);
  endtask

  // driver: inputs change 2 time units after the falling edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      out_ready = (or_mode == 2) ? 1'($urandom_range(0, 1)) : (or_mode == 1);
      if (stim_q.size() > 0 && (!iv_rand || $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1;
        in_row   = stim_q[0].row;
        in_tr    = stim_q[0].tr;
      end else begin
        in_valid = 1'b0;
        for (int i = 0; i < 144; i++) in_row[i] = 1'($urandom_range(0, 1));
        in_tr = 1'($urandom_range(0, 1));
      end
    end
  end

  // model advance on the active edge, using the model's own ready/valid
  always @(posedge clk) begin
    bit acc, emt;
    if (c_rst) begin
      acc = in_valid && (done_q.size() < 2);
      emt = (done_q.size() > 0) && out_ready;
      if (c_valid && out_ready) dut_beats++;
      if (emt) begin
        m_emit++;
        if (m_beat == n - 1) begin
          void'(done_q.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (acc) begin
        if (stim_q.size() > 0) void'(stim_q.pop_front());
        if (cur_n == 0) cur.tr = in_tr;
        cur.r[cur_n] = in_row & rmask;
        m_acc++;
        cur_n++;
        if (cur_n == n) begin
          done_q.push_back(cur);
          cur_n = 0;
        end
      end
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    checkv("in_ready",  144'(c_ready), 144'(done_q.size() < 2));
    checkv("out_valid", 144'(c_valid), 144'(done_q.size() > 0));
    checkv("out_vec",   c_vec, exp_vec());
    checkv("out_last",  144'(c_last), 144'((done_q.size() > 0) && (m_beat == n - 1)));
  end

  initial begin
    int cyc, first, lastv, nv, nr;
    stim_t s;
    logic tr0;

    // reset
    repeat (3) @(negedge clk);
    #3 rst8_n = 1'b1;
    @(negedge clk);
    checkv("reset_in_ready", 144'(r8), 144'd1);
    checkv("reset_out_valid", 144'(v8), 144'd0);

    // single transpose block, element (r,c) = r*8+c
    m_acc = 0; m_emit = 0; or_mode = 1;
    push_block(0, 1'b1, 1'b0);
    wait_cnt("t1_fill", 1'b0, 8, 50);
    checkv("t1_valid_after_8th", 144'(v8), 144'd1);
    checkv("t1_b0_e2", el(vec8, 2), 144'd16);
    checkv("t1_b0_e7", el(vec8, 7), 144'd56);
    checkv("t1_model_pin", el(exp_vec(), 7), 144'd56);
    checkv("t1_b0_last", 144'(l8), 144'd0);
    repeat (7) @(negedge clk);
    checkv("t1_b7_last", 144'(l8), 144'd1);
    checkv("t1_b7_e1", el(vec8, 1), 144'd15);
    @(negedge clk);
    checkv("t1_after_valid", 144'(v8), 144'd0);

    // streaming: 4 back-to-back blocks
    m_acc = 0; m_emit = 0;
    for (int b = 0; b < 4; b++) push_block(1000 * (b + 1), 1'b1, 1'b0);
    cyc = 0; first = -1; lastv = -1; nv = 0; nr = 0;
    while (m_emit < 32 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!r8) nr++;
      if (v8) begin
        nv++;
        if (first < 0) first = cyc;
        lastv = cyc;
      end
    end
    checkv("t2_done", 144'(m_emit), 144'd32);
    checkv("t2_ready_drops", 144'(nr), 144'd0);
    checkv("t2_first_valid", 144'(first), 144'd8);
    checkv("t2_valid_beats", 144'(nv), 144'd32);
    checkv("t2_contiguous", 144'(lastv - first), 144'd31);

    // back-pressure: 16 accepts fill both banks, 17th row stalls
    @(negedge clk);
    m_acc = 0; m_emit = 0; or_mode = 0;
    push_block(0, 1'b1, 1'b0);
    push_block(500, 1'b1, 1'b0);
    push_block(700, 1'b0, 1'b0);
    wait_cnt("t3_fill", 1'b0, 16, 60);
    checkv("t3_ready_low", 144'(r8), 144'd0);
    checkv("t3_b0_e4", el(vec8, 4), 144'd32);
    repeat (3) @(negedge clk);
    checkv("t3_stall_ready", 144'(r8), 144'd0);
    checkv("t3_stall_e4", el(vec8, 4), 144'd32);
    or_mode = 1;
    wait_cnt("t3_drain7", 1'b1, 7, 20);
    checkv("t3_last", 144'(l8), 144'd1);
    checkv("t3_last_e0", el(vec8, 0), 144'd7);
    checkv("t3_last_ready", 144'(r8), 144'd0);
    @(negedge clk);
    checkv("t3_ready_back", 144'(r8), 144'd1);
    wait_cnt("t3_all", 1'b1, 24, 100);

    // mixed modes, in_tr toggled inside each block
    m_acc = 0; m_emit = 0;
    push_block(100, 1'b1, 1'b1);
    push_block(200, 1'b0, 1'b1);
    wait_cnt("t4_a1", 1'b1, 1, 60);
    checkv("t4_a_b1_e2", el(vec8, 2), 144'd117);
    wait_cnt("t4_b3", 1'b1, 11, 60);
    checkv("t4_b_valid", 144'(v8), 144'd1);
    checkv("t4_b_b3_e0", el(vec8, 0), 144'd224);
    checkv("t4_b_b3_e5", el(vec8, 5), 144'd229);
    wait_cnt("t4_all", 1'b1, 16, 60);

    // reset with block 1 partly drained and block 2 partly written
    m_acc = 0; m_emit = 0;
    push_block(300, 1'b1, 1'b0);
    push_block(400, 1'b1, 1'b0);
    wait_cnt("t5_pre", 1'b0, 11, 60);
    #3 rst8_n = 1'b0;
    model_clear();
    #1;
    checkv("t5_rst_ready", 144'(r8), 144'd1);
    checkv("t5_rst_valid", 144'(v8), 144'd0);
    checkv("t5_rst_vec", vec8, 144'd0);
    checkv("t5_rst_last", 144'(l8), 144'd0);
    repeat (2) @(negedge clk);
    #3 rst8_n = 1'b1;
    m_acc = 0; m_emit = 0;
    push_block(50, 1'b1, 1'b0);
    wait_cnt("t5_fill", 1'b0, 8, 50);
    checkv("t5_fresh_valid", 144'(v8), 144'd1);
    checkv("t5_fresh_e1", el(vec8, 1), 144'd58);
    wait_cnt("t5_all", 1'b1, 8, 50);

    // random handshakes, 100 blocks on the N=4 W=12 instance
    @(negedge clk);
    #3 rst8_n = 1'b0;
    model_clear();
    sel = 1'b1; n = 4; w = 12;
    emask = (144'd1 << 12) - 144'd1;
    rmask = (144'd1 << 48) - 144'd1;
    rst4_n = 1'b1;
    iv_rand = 1'b1; or_mode = 2;
    m_acc = 0; m_emit = 0; dut_beats = 0;
    for (int b = 0; b < 100; b++) begin
      tr0 = 1'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++) begin
        s.row = '0;
        for (int c = 0; c < 4; c++) s.row |= 144'($urandom_range(0, 4095)) << (c * 12);
        s.tr = (r == 0) ? tr0 : 1'($urandom_range(0, 1));
        stim_q.push_back(s);
      end
    end
    wait_cnt("t6_all", 1'b1, 400, 20000);
    repeat (3) @(negedge clk);
    checkv("t6_beat_count", 144'(dut_beats), 144'd400);
    checkv("t6_idle_valid", 144'(v4), 144'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
